gate_scheduler: RTL

Sequencer for the suppressor gating window. Latches a window configuration on `arm` and issues `sup_start` pulses to one suppressor instance. Pulses come either periodically for a programmed number of windows, or from an external trigger with hold-off and drop counting. Sits between the register file / trigger logic and the suppressor, which it drives with stable shadow copies of `delay_cnt`/`total_cnt`.

---
 rtl/gate_scheduler_pkg.sv | 16 +
 rtl/gate_scheduler_if.sv | 50 +++++
 rtl/gate_scheduler_timer.sv | 44 ++++
 rtl/gate_scheduler.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/gate_scheduler_pkg.sv
// Shared types for the suppressor gating-window scheduler.
//   sched_state_t : sequencer state (IDLE, RUN, DRAIN), exported for debug
//   MODE_PERIODIC : starts generated from the programmed period
//   MODE_EXT      : starts generated from ext_trig rising edges
package gate_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_EXT      = 1'b1;

endpackage

// File: rtl/gate_scheduler_if.sv
// Bundle between the register file / trigger logic (master) and the
// gate scheduler (slave).
//   master drives : arm, abort, cfg_*, ext_trig
//   slave drives  : sup_start, sup_clr, sup_delay_cnt, sup_total_cnt,
//                   busy, done, win_idx, drop_cnt, dbg_state
// Handshake: there is no ready path. arm and abort are single-cycle strobes
// sampled on every rising clock edge; the scheduler always accepts them,
// ignoring arm while busy and letting abort win when both are high.
// sup_start, sup_clr and done are single-cycle registered strobes.
interface gate_scheduler_if #(
    parameter int CW = 32,
    parameter int NW = 16,
    parameter int DW = 16
);
    import gate_sched_pkg::*;

    logic          arm;
    logic          abort;
    logic          cfg_mode;
    logic [CW-1:0] cfg_delay_cnt;
    logic [CW-1:0] cfg_total_cnt;
    logic [CW-1:0] cfg_period;
    logic [NW-1:0] cfg_num_win;
    logic          ext_trig;

    logic          sup_start;
    logic          sup_clr;
    logic [CW-1:0] sup_delay_cnt;
    logic [CW-1:0] sup_total_cnt;
    logic          busy;
    logic          done;
    logic [NW-1:0] win_idx;
    logic [DW-1:0] drop_cnt;
    sched_state_t  dbg_state;

    modport master (
        output arm, abort, cfg_mode, cfg_delay_cnt, cfg_total_cnt,
               cfg_period, cfg_num_win, ext_trig,
        input  sup_start, sup_clr, sup_delay_cnt, sup_total_cnt,
               busy, done, win_idx, drop_cnt, dbg_state
    );

    modport slave (
        input  arm, abort, cfg_mode, cfg_delay_cnt, cfg_total_cnt,
               cfg_period, cfg_num_win, ext_trig,
        output sup_start, sup_clr, sup_delay_cnt, sup_total_cnt,
               busy, done, win_idx, drop_cnt, dbg_state
    );

endinterface

// File: rtl/gate_scheduler_timer.sv
// sched_timer: loadable down-counter that saturates at zero.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : load load_val_i this cycle (takes priority over counting)
//   load_val_i  : value to load
//   val_o       : current count
//   zero_o      : count is zero
//   le1_o       : count is zero or one
module sched_timer #(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic [CW-1:0] val_o,
    output logic          zero_o,
    output logic          le1_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign val_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
    assign le1_o  = (cnt_q <= CW'(1));

endmodule

// File: rtl/gate_scheduler.sv
// gate_scheduler: sequences sup_start pulses for one suppressor instance,
// either periodically for a programmed number of windows or from rising
// edges of ext_trig with hold-off and drop counting.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : gate_scheduler_if slave modport (config/strobes in,
//                suppressor drive, status and debug state out)
// All outputs are registered.
module gate_scheduler
    import gate_sched_pkg::*;
#(
    parameter int CW = 32,
    parameter int NW = 16,
    parameter int DW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    gate_scheduler_if.slave  bus
);

    sched_state_t  state_q,     state_d;
    logic          sup_start_q, sup_start_d;
    logic          sup_clr_q,   sup_clr_d;
    logic          done_q,      done_d;
    logic          busy_q,      busy_d;
    logic [CW-1:0] delay_q,     delay_d;
    logic [CW-1:0] total_q,     total_d;
    logic [CW-1:0] peff_q,      peff_d;
    logic          mode_q,      mode_d;
    logic [NW-1:0] num_win_q,   num_win_d;
    logic [NW-1:0] win_idx_q,   win_idx_d;
    logic [DW-1:0] drop_q,      drop_d;
    logic          trig_prev_q;

    logic          trig_edge;
    logic          start_w;
    logic          win_load,    per_load;
    logic [CW-1:0] win_load_val, per_load_val;
    logic [CW-1:0] win_val,     per_val;
    logic          win_zero,    per_zero;
    logic          win_le1,     per_le1;
    logic          unused_timer;

    // win_rem: remaining cycles of the current suppressor window.
    sched_timer #(.CW(CW)) u_win_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (win_load),
        .load_val_i (win_load_val),
        .val_o      (win_val),
        .zero_o     (win_zero),
        .le1_o      (win_le1)
    );

    // Periodic spacing between starts.
    sched_timer #(.CW(CW)) u_per_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (per_load),
        .load_val_i (per_load_val),
        .val_o      (per_val),
        .zero_o     (per_zero),
        .le1_o      (per_le1)
    );

    assign unused_timer = ^{win_val, per_val, win_zero, per_zero};

    assign trig_edge = bus.ext_trig & ~trig_prev_q;

    always_comb begin
        state_d      = state_q;
        sup_start_d  = 1'b0;
        sup_clr_d    = 1'b0;
        done_d       = 1'b0;
        delay_d      = delay_q;
        total_d      = total_q;
        peff_d       = peff_q;
        mode_d       = mode_q;
        num_win_d    = num_win_q;
        win_idx_d    = win_idx_q;
        drop_d       = drop_q;
        start_w      = 1'b0;
        win_load     = 1'b0;
        win_load_val = '0;
        per_load     = 1'b0;
        per_load_val = '0;

        if (bus.abort) begin
            // Abort outranks everything, including a same-cycle arm.
            sup_clr_d = 1'b1;
            state_d   = IDLE;
            win_load  = 1'b1;
            per_load  = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.arm) begin
                        delay_d   = bus.cfg_delay_cnt;
                        total_d   = bus.cfg_total_cnt;
                        // Starts never come closer than one window apart.
                        peff_d    = (bus.cfg_period > bus.cfg_total_cnt) ?
                                    bus.cfg_period : bus.cfg_total_cnt;
                        mode_d    = bus.cfg_mode;
                        num_win_d = bus.cfg_num_win;
                        win_idx_d = '0;
                        drop_d    = '0;
                        win_load  = 1'b1;
                        if (bus.cfg_total_cnt == '0) begin
                            done_d = 1'b1;
                        end else if (bus.cfg_mode == MODE_PERIODIC) begin
                            start_w = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (mode_q == MODE_PERIODIC) begin
                        if (per_le1) start_w = 1'b1;
                    end else if (trig_edge) begin
                        // win_rem <= 1 lets the next start land on the
                        // suppressor's last active cycle.
                        if (win_le1) begin
                            start_w = 1'b1;
                        end else if (drop_q != '1) begin
                            drop_d = drop_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (win_le1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (start_w) begin
                sup_start_d  = 1'b1;
                win_load     = 1'b1;
                win_load_val = total_d;
                per_load     = 1'b1;
                per_load_val = peff_d;
                win_idx_d    = win_idx_d + 1'b1;
                state_d      = (num_win_d != '0 && win_idx_d == num_win_d) ?
                               DRAIN : RUN;
            end
        end
    end

    assign busy_d = (state_d != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sup_start_q <= 1'b0;
            sup_clr_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            delay_q     <= '0;
            total_q     <= '0;
            peff_q      <= '0;
            mode_q      <= MODE_PERIODIC;
            num_win_q   <= '0;
            win_idx_q   <= '0;
            drop_q      <= '0;
            trig_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sup_start_q <= sup_start_d;
            sup_clr_q   <= sup_clr_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            delay_q     <= delay_d;
            total_q     <= total_d;
            peff_q      <= peff_d;
            mode_q      <= mode_d;
            num_win_q   <= num_win_d;
            win_idx_q   <= win_idx_d;
            drop_q      <= drop_d;
            trig_prev_q <= bus.ext_trig;
        end
    end

    assign bus.sup_start     = sup_start_q;
    assign bus.sup_clr       = sup_clr_q;
    assign bus.sup_delay_cnt = delay_q;
    assign bus.sup_total_cnt = total_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.win_idx       = win_idx_q;
    assign bus.drop_cnt      = drop_q;
    assign bus.dbg_state     = state_q;

endmodule
